// File: rtl/controle_pkg.sv
// Shared types and verdict encodings for the verdict sequencer.
// Verdict bit order is {aceito, comprometido, recusado}, matching the decoder.
package controle_pkg;

    typedef enum logic [2:0] {
        OCIOSO,
        MOSTRA,
        BIP_ON,
        BIP_OFF,
        PAUSA
    } estado_e;

    localparam logic [2:0] V_ACEITO       = 3'b100;
    localparam logic [2:0] V_COMPROMETIDO = 3'b010;
    localparam logic [2:0] V_RECUSADO     = 3'b001;
    localparam logic [2:0] V_NENHUM       = 3'b000;

    function automatic logic eh_veredito(input logic [2:0] v);
        return (v == V_ACEITO) || (v == V_COMPROMETIDO) || (v == V_RECUSADO);
    endfunction

endpackage

// File: rtl/controle_veredito_temporizador.sv
// Loadable down-counter; expira is high while the count sits at 1.
// Saturates at 0 so an idle timer never raises expira.
module temporizador #(
    parameter int unsigned LARGURA = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               carga_i,
    input  logic [LARGURA-1:0] valor_i,
    output logic               expira_o
);

    logic [LARGURA-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (carga_i) begin
            cnt_q <= valor_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign expira_o = (cnt_q == LARGURA'(1));

endmodule

// File: rtl/controle_veredito.sv
// Verdict sequencer: shows aceito/comprometido steadily, blinks recusado, then blanks.
// One pending slot catches verdicts that arrive while a previous one is still on display.
module controle_veredito
    import controle_pkg::*;
#(
    parameter int unsigned HOLD_CYC = 50_000_000,
    parameter int unsigned BEEP_CYC = 12_500_000,
    parameter int unsigned N_BEEPS  = 3,
    parameter int unsigned GAP_CYC  = 5_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic valido,
    input  logic aceito_in,
    input  logic comprometido_in,
    input  logic recusado_in,
    output logic aceito,
    output logic comprometido,
    output logic recusado,
    output logic ocupado,
    output logic pendente,
    output logic descartado,
    output logic invalido
);

    localparam int unsigned MaxHb  = (HOLD_CYC > BEEP_CYC) ? HOLD_CYC : BEEP_CYC;
    localparam int unsigned MaxCyc = (MaxHb > GAP_CYC) ? MaxHb : GAP_CYC;
    localparam int unsigned TW     = $clog2(MaxCyc + 1);
    localparam int unsigned BW     = $clog2(N_BEEPS + 1);

    localparam logic [TW-1:0] HoldV     = TW'(HOLD_CYC);
    localparam logic [TW-1:0] BeepV     = TW'(BEEP_CYC);
    localparam logic [TW-1:0] GapV      = TW'(GAP_CYC);
    localparam logic [BW-1:0] UltimoBip = BW'(N_BEEPS - 1);

    estado_e        st_q, st_d;
    logic [2:0]     verd_q, verd_d;
    logic [2:0]     pend_q, pend_d;
    logic           pend_v_q, pend_v_d;
    logic [BW-1:0]  beep_q, beep_d;

    logic [2:0]     entrada;
    logic           unico;
    logic           carrega;
    logic [2:0]     novo;
    logic           carga;
    logic [TW-1:0]  valor;
    logic           expira;

    logic [2:0]     linhas_d;
    logic           ocup_d;
    logic           desc_d;
    logic           inval_d;

    temporizador #(
        .LARGURA (TW)
    ) u_temporizador (
        .clk      (clk),
        .rst      (rst),
        .carga_i  (carga),
        .valor_i  (valor),
        .expira_o (expira)
    );

    always_comb begin
        entrada  = {aceito_in, comprometido_in, recusado_in};
        unico    = valido && eh_veredito(entrada);
        inval_d  = valido && !eh_veredito(entrada);
        st_d     = st_q;
        verd_d   = verd_q;
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        beep_d   = beep_q;
        desc_d   = 1'b0;
        carrega  = 1'b0;
        novo     = V_NENHUM;
        carga    = 1'b0;
        valor    = '0;

        case (st_q)
            OCIOSO: begin
                if (unico) begin
                    carrega = 1'b1;
                    novo    = entrada;
                end
            end
            MOSTRA: begin
                if (expira) begin
                    st_d  = PAUSA;
                    carga = 1'b1;
                    valor = GapV;
                end
            end
            BIP_ON: begin
                if (expira) begin
                    st_d  = BIP_OFF;
                    carga = 1'b1;
                    valor = BeepV;
                end
            end
            BIP_OFF: begin
                if (expira) begin
                    carga = 1'b1;
                    if (beep_q == UltimoBip) begin
                        st_d  = PAUSA;
                        valor = GapV;
                    end else begin
                        beep_d = beep_q + 1'b1;
                        st_d   = BIP_ON;
                        valor  = BeepV;
                    end
                end
            end
            PAUSA: begin
                if (expira) begin
                    if (pend_v_q) begin
                        // Older pending verdict goes on display; a same-cycle strobe refills the slot.
                        carrega  = 1'b1;
                        novo     = pend_q;
                        pend_v_d = unico;
                        if (unico) begin
                            pend_d = entrada;
                        end
                    end else if (unico) begin
                        carrega = 1'b1;
                        novo    = entrada;
                    end else begin
                        st_d  = OCIOSO;
                        carga = 1'b1;
                    end
                end
            end
            default: st_d = OCIOSO;
        endcase

        if (st_q != OCIOSO && unico && !(st_q == PAUSA && expira)) begin
            desc_d   = pend_v_q;
            pend_d   = entrada;
            pend_v_d = 1'b1;
        end

        if (carrega) begin
            verd_d = novo;
            beep_d = '0;
            carga  = 1'b1;
            if (novo == V_RECUSADO) begin
                st_d  = BIP_ON;
                valor = BeepV;
            end else begin
                st_d  = MOSTRA;
                valor = HoldV;
            end
        end

        linhas_d = V_NENHUM;
        if (st_d == MOSTRA) begin
            linhas_d = verd_d;
        end else if (st_d == BIP_ON) begin
            linhas_d = V_RECUSADO;
        end
        ocup_d = (st_d != OCIOSO);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q         <= OCIOSO;
            verd_q       <= V_NENHUM;
            pend_q       <= V_NENHUM;
            pend_v_q     <= 1'b0;
            beep_q       <= '0;
            aceito       <= 1'b0;
            comprometido <= 1'b0;
            recusado     <= 1'b0;
            ocupado      <= 1'b0;
            pendente     <= 1'b0;
            descartado   <= 1'b0;
            invalido     <= 1'b0;
        end else begin
            st_q         <= st_d;
            verd_q       <= verd_d;
            pend_q       <= pend_d;
            pend_v_q     <= pend_v_d;
            beep_q       <= beep_d;
            aceito       <= linhas_d[2];
            comprometido <= linhas_d[1];
            recusado     <= linhas_d[0];
            ocupado      <= ocup_d;
            pendente     <= pend_v_d;
            descartado   <= desc_d;
            invalido     <= inval_d;
        end
    end

endmodule

// File: tb/tb_controle_veredito.sv
// Scoreboard bench for controle_veredito with short timing parameters.
module tb_controle_veredito;

    localparam logic [2:0] VA = 3'b100;
    localparam logic [2:0] VC = 3'b010;
    localparam logic [2:0] VR = 3'b001;
    localparam logic [2:0] VN = 3'b000;

    // {aceito, comprometido, recusado, ocupado, pendente, descartado, invalido}
    localparam logic [6:0] E_0 = 7'b0000000;
    localparam logic [6:0] E_A = 7'b1001000;
    localparam logic [6:0] E_C = 7'b0101000;
    localparam logic [6:0] E_R = 7'b0011000;
    localparam logic [6:0] E_B = 7'b0001000;
    localparam logic [6:0] F_P = 7'b0000100;
    localparam logic [6:0] F_D = 7'b0000010;
    localparam logic [6:0] F_I = 7'b0000001;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic valido = 1'b0;
    logic a_in = 1'b0, c_in = 1'b0, r_in = 1'b0;
    logic aceito, comprometido, recusado, ocupado, pendente, descartado, invalido;
    logic [6:0] obs;
    logic [6:0] sb[$];
    int n_vec = 0;
    int n_err = 0;

    controle_veredito #(
        .HOLD_CYC (8),
        .BEEP_CYC (2),
        .N_BEEPS  (3),
        .GAP_CYC  (2)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .valido          (valido),
        .aceito_in       (a_in),
        .comprometido_in (c_in),
        .recusado_in     (r_in),
        .aceito          (aceito),
        .comprometido    (comprometido),
        .recusado        (recusado),
        .ocupado         (ocupado),
        .pendente        (pendente),
        .descartado      (descartado),
        .invalido        (invalido)
    );

    always #5 clk = ~clk;

    assign obs = {aceito, comprometido, recusado, ocupado, pendente, descartado, invalido};

    // Drives one edge's inputs and returns #1 after that edge.
    task automatic drive(input logic v, input logic [2:0] ver);
        valido = v;
        {a_in, c_in, r_in} = ver;
        @(posedge clk);
        #1;
        valido = 1'b0;
        {a_in, c_in, r_in} = VN;
    endtask

    task automatic push_n(input int n, input logic [6:0] e);
        repeat (n) sb.push_back(e);
    endtask

    task automatic push_blink();
        push_n(2, E_R); push_n(2, E_B);
        push_n(2, E_R); push_n(2, E_B);
        push_n(2, E_R); push_n(4, E_B);
    endtask

    task automatic test_reset();
        #2;
        n_vec++;
        if (obs !== E_0) begin
            n_err++;
            $display("FAIL reset_async: got %b want %b", obs, E_0);
        end
        @(posedge clk);
        #1;
        n_vec++;
        if (obs !== E_0) begin
            n_err++;
            $display("FAIL reset_held: got %b want %b", obs, E_0);
        end
        rst = 1'b0;
        drive(1'b0, VN);
    endtask

    task automatic test_aceito();
        logic [6:0] exp;
        push_n(8, E_A); push_n(2, E_B); push_n(2, E_0);
        for (int c = 0; c < 12; c++) begin
            if (c == 0) drive(1'b1, VA); else drive(1'b0, VN);
            exp = sb.pop_front();
            n_vec++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL aceito cycle %0d: got %b want %b", c + 1, obs, exp);
            end
        end
    endtask

    task automatic test_recusado();
        logic [6:0] exp;
        push_blink(); push_n(1, E_0);
        for (int c = 0; c < 15; c++) begin
            if (c == 0) drive(1'b1, VR); else drive(1'b0, VN);
            exp = sb.pop_front();
            n_vec++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL recusado cycle %0d: got %b want %b", c + 1, obs, exp);
            end
        end
    endtask

    task automatic test_descarte();
        logic [6:0] exp;
        push_n(3, E_A); push_n(2, E_A | F_P); push_n(1, E_A | F_P | F_D);
        push_n(1, E_A | F_P); push_n(1, E_A | F_P | F_I); push_n(2, E_B | F_P);
        push_blink(); push_n(1, E_0);
        for (int c = 0; c < 25; c++) begin
            case (c)
                0:       drive(1'b1, VA);
                3:       drive(1'b1, VC);
                5:       drive(1'b1, VR);
                7:       drive(1'b1, 3'b111);
                default: drive(1'b0, VN);
            endcase
            exp = sb.pop_front();
            n_vec++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL descarte cycle %0d: got %b want %b", c + 1, obs, exp);
            end
        end
    endtask

    task automatic test_invalido();
        logic [6:0] exp;
        push_n(1, F_I); push_n(1, E_0); push_n(1, F_I); push_n(1, E_0);
        for (int c = 0; c < 4; c++) begin
            case (c)
                0:       drive(1'b1, 3'b110);
                2:       drive(1'b1, VN);
                default: drive(1'b0, VN);
            endcase
            exp = sb.pop_front();
            n_vec++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL invalido cycle %0d: got %b want %b", c + 1, obs, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] exp;
        push_n(3, E_A); push_n(5, E_A | F_P); push_n(2, E_B | F_P);
        push_n(8, E_C | F_P); push_n(2, E_B | F_P);
        push_blink(); push_n(1, E_0);
        for (int c = 0; c < 35; c++) begin
            case (c)
                0:       drive(1'b1, VA);
                3:       drive(1'b1, VC);
                10:      drive(1'b1, VR);
                default: drive(1'b0, VN);
            endcase
            exp = sb.pop_front();
            n_vec++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL back_to_back cycle %0d: got %b want %b", c + 1, obs, exp);
            end
        end
    endtask

    task automatic test_pausa_direta();
        logic [6:0] exp;
        push_n(8, E_A); push_n(2, E_B); push_n(8, E_C); push_n(2, E_B); push_n(1, E_0);
        for (int c = 0; c < 21; c++) begin
            case (c)
                0:       drive(1'b1, VA);
                10:      drive(1'b1, VC);
                default: drive(1'b0, VN);
            endcase
            exp = sb.pop_front();
            n_vec++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL pausa_direta cycle %0d: got %b want %b", c + 1, obs, exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [6:0] exp;
        push_n(2, E_C); push_n(1, E_C | F_P);
        for (int c = 0; c < 3; c++) begin
            case (c)
                0:       drive(1'b1, VC);
                2:       drive(1'b1, VR);
                default: drive(1'b0, VN);
            endcase
            exp = sb.pop_front();
            n_vec++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL reset_mid_pre cycle %0d: got %b want %b", c + 1, obs, exp);
            end
        end
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if (obs !== E_0) begin
            n_err++;
            $display("FAIL reset_mid_async: got %b want %b", obs, E_0);
        end
        @(posedge clk);
        #1;
        n_vec++;
        if (obs !== E_0) begin
            n_err++;
            $display("FAIL reset_mid_held: got %b want %b", obs, E_0);
        end
        rst = 1'b0;
        push_n(2, E_0); push_n(8, E_A); push_n(2, E_B); push_n(1, E_0);
        for (int c = 0; c < 13; c++) begin
            if (c == 2) drive(1'b1, VA); else drive(1'b0, VN);
            exp = sb.pop_front();
            n_vec++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL reset_mid_post cycle %0d: got %b want %b", c + 1, obs, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_aceito();
        test_recusado();
        test_descarte();
        test_invalido();
        test_back_to_back();
        test_pausa_direta();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
